fu_wb_queue: RTL and testbench
==============================

# fu_wb_queue

Result buffer sitting directly downstream of the arithmetic functional unit's `fu` modport. It captures each completed result bundle, holding up to `MAX_OPERANDS` destination writes plus an instruction ID. It serializes the valid writes onto one shared register-file write port, arbitrated by `rf_wr_grant`. After the last write of a bundle it pulses a completion to the ROB. When full it deasserts `in_ready`, which the FU control folds into `fu_ready`.

## Interface
Parameters:
- `INST_ID_BITS`, 6: instruction ID width.
- `PRN_BITS`, 6: physical register number width.
- `MAX_OPERANDS`, 3: result slots per FU bundle.
- `DEPTH`, 4: queue entries (power of two, ≥2).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `fu_out_prn`  in  `[PRN_BITS-1:0]` × `MAX_OPERANDS`: destination PRN per slot.
- `fu_out_data`  in  `[63:0]` × `MAX_OPERANDS`: result data per slot.
- `fu_out_data_valid`  in  1 × `MAX_OPERANDS`: slot carries a write.
- `fu_out_inst_id`  in  `INST_ID_BITS`: producing instruction.
- `fu_out_valid`  in  1: bundle present this cycle.
- `in_ready`  out  1: queue can accept a bundle this cycle.
- `rf_wr_en`  out  1: write request on the shared RF port.
- `rf_wr_prn`  out  `PRN_BITS`: write PRN.
- `rf_wr_data`  out  64: write data.
- `rf_wr_grant`  in  1: RF port granted this cycle.
- `done_valid`  out  1: one-cycle ROB completion pulse.
- `done_inst_id`  out  `INST_ID_BITS`: completing instruction.

## Operation
- Each entry holds the bundle plus `pend[MAX_OPERANDS]`, initialised from `fu_out_data_valid`.
- Entries live in a circular buffer with head/tail pointers of width `$clog2(DEPTH)` and a count of width `$clog2(DEPTH)+1`. Pointers wrap at `DEPTH`.
- Push: `fu_out_valid && in_ready` at a clock edge writes the tail entry. `fu_out_valid` without `in_ready` is dropped; the FU must hold the bundle.
- `in_ready` = `!rst && count < DEPTH`. It depends on count only, never on a same-cycle pop.
- Head serializer, when the head entry has a nonzero `pend`:
  - Selects the lowest set index `k`.
  - Drives `rf_wr_en`=1 and the `prn`/`data` of slot `k`.
  - On `rf_wr_grant`, clears `pend[k]`.
- If the granted write clears the last pending bit, `done_valid`=1 with the head's `inst_id` in the same cycle, and the head pops at that edge.
- Head with all-zero `pend` (no-write instruction): `rf_wr_en`=0, `done_valid`=1, and the head pops that cycle without needing a grant.
- Empty queue: `rf_wr_en`=0 and `done_valid`=0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- `rf_wr_grant` while `rf_wr_en`=0 is ignored.
- Reset:
  - Count, pointers and all `pend` bits clear; entry data is don't-care.
  - Any in-flight bundle is discarded, including a partially written head. Its remaining writes and its `done` are lost; the flush is owned by the ROB.
  - In the reset cycle `in_ready`=0, `rf_wr_en`=0 and `done_valid`=0.
  - Output data buses are 0 whenever the corresponding valid/enable is 0.

## Timing
- Unbypassed latency: bundle accepted at edge N → earliest `rf_wr_en` in cycle N+1.
- A bundle with w valid writes and continuous grant occupies the head for max(w,1) cycles. Sustained throughput is one RF write per cycle.
- `done_valid` coincides with the last granted write and is never later.
- Completions leave in acceptance order (FIFO). `inst_id` values are never reordered.
- Outputs are combinational from the head entry and `pend`; all state changes on the rising edge.

## Configuration
- `FU_WB_BYPASS_EN` defined: when count==0 and `fu_out_valid`, the incoming bundle drives the serializer in the same cycle (zero-cycle latency). The ROB must tolerate a same-cycle completion.
  - Bypassed bundle fully satisfied that cycle (its single write granted, or no writes): it is not enqueued and `done_valid`=1 in that cycle.
  - Otherwise it is enqueued with the granted slot's `pend` bit already cleared.
  - `in_ready` is unchanged.
- `FU_WB_BYPASS_EN` undefined: no bypass; the head is always a stored entry and latency is ≥1 cycle as stated under Timing.

## Test plan
- Single write, grant held high: push id=5, slot0 PRN=12 data=0xDEAD. Cycle N+1 shows `rf_wr_en`=1, PRN 12, data 0xDEAD, `done_valid`=1 with id 5, and count returns to 0. With bypass, all of this happens in cycle N.
- Three writes: push id=2 with slots {PRN 1, 2, 3}. Writes issue in order PRN 1,2,3 on consecutive cycles and `done` (id 2) fires in the third cycle only.
- Grant stall: same three-write bundle with grant low for 4 cycles. The PRN 1 request holds stable for those 4 cycles, there is no `done`, and the writes then complete as in the previous scenario.
- Full queue (`DEPTH`=4): push 4 bundles with grant low. `in_ready`=0, a 5th `fu_out_valid` is not accepted, and raising grant drains ids in push order.
- No-write bundle: push id=9 with all `fu_out_data_valid`=0. `done_valid` fires with id 9 without any grant and `rf_wr_en` stays 0.
- Mid-operation reset: assert `rst` after 1 of 3 writes is granted. Next cycle count=0, `rf_wr_en`=0 and no `done` for that id; after reset deasserts, `in_ready`=1.

Source files
------------

// File: rtl/fu_wb_queue.sv
// FU result write-back queue: buffers FU result bundles and serializes their writes onto one RF port.
// Define FU_WB_BYPASS_EN to let a bundle arriving at an empty queue drive the RF port in the same cycle.
module fu_wb_queue #(
  parameter int unsigned INST_ID_BITS = 6,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  fu_out_prn,
  input  logic [MAX_OPERANDS-1:0][63:0]          fu_out_data,
  input  logic [MAX_OPERANDS-1:0]                fu_out_data_valid,
  input  logic [INST_ID_BITS-1:0]                fu_out_inst_id,
  input  logic                                   fu_out_valid,
  output logic                                   in_ready,
  output logic                                   rf_wr_en,
  output logic [PRN_BITS-1:0]                    rf_wr_prn,
  output logic [63:0]                            rf_wr_data,
  input  logic                                   rf_wr_grant,
  output logic                                   done_valid,
  output logic [INST_ID_BITS-1:0]                done_inst_id
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SelW = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;

  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_prn  [DEPTH];
  logic [MAX_OPERANDS-1:0][63:0]         r_data [DEPTH];
  logic [MAX_OPERANDS-1:0]               r_pend [DEPTH];
  logic [INST_ID_BITS-1:0]               r_id   [DEPTH];
  logic [PtrW-1:0]                       r_head;
  logic [PtrW-1:0]                       r_tail;
  logic [CntW-1:0]                       r_count;

  logic                                  w_byp;
  logic                                  w_src_vld;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] w_src_prn;
  logic [MAX_OPERANDS-1:0][63:0]         w_src_data;
  logic [MAX_OPERANDS-1:0]               w_src_pend;
  logic [INST_ID_BITS-1:0]               w_src_id;
  logic [SelW-1:0]                       w_sel;
  logic [MAX_OPERANDS-1:0]               w_pend_nxt;
  logic                                  w_grant;
  logic                                  w_push;
  logic                                  w_pop;

`ifdef FU_WB_BYPASS_EN
  assign w_byp = !rst && fu_out_valid && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  // Serializer source: the incoming bundle when bypassing, otherwise the head entry.
  always_comb begin
    w_src_vld  = !rst && (r_count != '0);
    w_src_prn  = r_prn[r_head];
    w_src_data = r_data[r_head];
    w_src_pend = r_pend[r_head];
    w_src_id   = r_id[r_head];
    if (w_byp) begin
      w_src_vld  = 1'b1;
      w_src_prn  = fu_out_prn;
      w_src_data = fu_out_data;
      w_src_pend = fu_out_data_valid;
      w_src_id   = fu_out_inst_id;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = MAX_OPERANDS - 1; i >= 0; i--) begin
      if (w_src_pend[i]) w_sel = SelW'(i);
    end
  end

  assign rf_wr_en = w_src_vld && (|w_src_pend);
  assign w_grant  = rf_wr_en && rf_wr_grant;

  always_comb begin
    w_pend_nxt = w_src_pend;
    if (w_grant) w_pend_nxt[w_sel] = 1'b0;
  end

  assign rf_wr_prn    = rf_wr_en ? w_src_prn[w_sel] : '0;
  assign rf_wr_data   = rf_wr_en ? w_src_data[w_sel] : '0;
  assign done_valid   = w_src_vld && (w_pend_nxt == '0);
  assign done_inst_id = done_valid ? w_src_id : '0;

  assign in_ready = !rst && (r_count < CntW'(DEPTH));
  // A bypassed bundle finished in its arrival cycle never occupies an entry.
  assign w_push   = fu_out_valid && in_ready && !(w_byp && done_valid);
  assign w_pop    = done_valid && !w_byp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_pend[i] <= '0;
    end else begin
      if (w_grant && !w_byp) r_pend[r_head] <= w_pend_nxt;
      if (w_push) begin
        r_prn[r_tail]  <= fu_out_prn;
        r_data[r_tail] <= fu_out_data;
        r_id[r_tail]   <= fu_out_inst_id;
        r_pend[r_tail] <= w_byp ? w_pend_nxt : fu_out_data_valid;
        r_tail         <= r_tail + PtrW'(1);
      end
      if (w_pop) r_head <= r_head + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

endmodule

// File: tb/tb_fu_wb_queue.sv
// Bench for fu_wb_queue: queue-level reference model checked every cycle plus directed literal checks.
// Honours FU_WB_BYPASS_EN the same way the design does.
module tb_fu_wb_queue;

  localparam int IDB = 6;
  localparam int PB  = 6;
  localparam int MO  = 3;
  localparam int D   = 4;
`ifdef FU_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct packed {
    logic [IDB-1:0]         id;
    logic [MO-1:0][PB-1:0]  prn;
    logic [MO-1:0][63:0]    data;
    logic [MO-1:0]          pend;
  } bund_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [MO-1:0][PB-1:0]  fu_out_prn;
  logic [MO-1:0][63:0]    fu_out_data;
  logic [MO-1:0]          fu_out_data_valid;
  logic [IDB-1:0]         fu_out_inst_id;
  logic                   fu_out_valid;
  logic                   in_ready;
  logic                   rf_wr_en;
  logic [PB-1:0]          rf_wr_prn;
  logic [63:0]            rf_wr_data;
  logic                   rf_wr_grant;
  logic                   done_valid;
  logic [IDB-1:0]         done_inst_id;

  int tests = 0;
  int fails = 0;
  bund_t mq[$];

  fu_wb_queue #(
    .INST_ID_BITS(IDB),
    .PRN_BITS    (PB),
    .MAX_OPERANDS(MO),
    .DEPTH       (D)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fu_out_prn       (fu_out_prn),
    .fu_out_data      (fu_out_data),
    .fu_out_data_valid(fu_out_data_valid),
    .fu_out_inst_id   (fu_out_inst_id),
    .fu_out_valid     (fu_out_valid),
    .in_ready         (in_ready),
    .rf_wr_en         (rf_wr_en),
    .rf_wr_prn        (rf_wr_prn),
    .rf_wr_data       (rf_wr_data),
    .rf_wr_grant      (rf_wr_grant),
    .done_valid       (done_valid),
    .done_inst_id     (done_inst_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bundles; the oldest one with pending writes owns the RF port.
  always @(negedge clk) begin : model
    bund_t src;
    bund_t inc;
    bit    have;
    bit    from_q;
    bit    e_en;
    bit    e_done;
    bit    e_rdy;
    int    k;
    logic [PB-1:0]  e_prn;
    logic [63:0]    e_data;
    logic [IDB-1:0] e_id;

    inc.id   = fu_out_inst_id;
    inc.prn  = fu_out_prn;
    inc.data = fu_out_data;
    inc.pend = fu_out_data_valid;
    src      = inc;
    e_rdy    = !rst && (mq.size() < D);
    have = 0; from_q = 0; e_en = 0; e_done = 0; e_prn = '0; e_data = '0; e_id = '0;

    chk("m_count", dut.r_count, mq.size());
    if (!rst) begin
      if (mq.size() > 0) begin
        src = mq[0]; have = 1; from_q = 1;
      end else if (Byp && fu_out_valid) begin
        have = 1;
      end
    end
    if (have) begin
      k = -1;
      for (int i = MO - 1; i >= 0; i--) if (src.pend[i]) k = i;
      if (k >= 0) begin
        e_en   = 1;
        e_prn  = src.prn[k];
        e_data = src.data[k];
        if (rf_wr_grant) src.pend[k] = 1'b0;
      end
      if (src.pend == '0) begin
        e_done = 1;
        e_id   = src.id;
      end
    end
    chk("m_in_ready", in_ready, e_rdy);
    chk("m_wr_en", rf_wr_en, e_en);
    chk("m_wr_prn", rf_wr_prn, e_prn);
    chk("m_wr_data", rf_wr_data, e_data);
    chk("m_done", done_valid, e_done);
    chk("m_done_id", done_inst_id, e_id);

    if (rst) begin
      mq.delete();
    end else begin
      if (from_q) begin
        if (e_done) void'(mq.pop_front());
        else mq[0] = src;
      end
      if (fu_out_valid && e_rdy) begin
        if (have && !from_q) begin
          if (!e_done) mq.push_back(src);
        end else begin
          mq.push_back(inc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fu_out_valid      = 1'b0;
    fu_out_inst_id    = '0;
    fu_out_prn        = '0;
    fu_out_data       = '0;
    fu_out_data_valid = '0;
  endtask

  task automatic drive(input logic [IDB-1:0] id, input logic [PB-1:0] p0, input logic [PB-1:0] p1,
                       input logic [PB-1:0] p2, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [MO-1:0] v);
    fu_out_valid      = 1'b1;
    fu_out_inst_id    = id;
    fu_out_prn[0]     = p0;
    fu_out_prn[1]     = p1;
    fu_out_prn[2]     = p2;
    fu_out_data[0]    = d0;
    fu_out_data[1]    = d1;
    fu_out_data[2]    = d2;
    fu_out_data_valid = v;
  endtask

  task automatic next();
    step();
    idle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rf_wr_grant = 1'b0;
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_done", done_valid, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    // Single write with grant held high.
    step();
    rf_wr_grant = 1'b1;
    drive(6'd5, 6'd12, 6'd0, 6'd0, 64'hDEAD, 64'd0, 64'd0, 3'b001);
    @(negedge clk);
    chk("s1_n_en", rf_wr_en, Byp);
    chk("s1_n_prn", rf_wr_prn, Byp ? 64'd12 : 64'd0);
    chk("s1_n_done", done_valid, Byp);
    next();
    chk("s1_n1_en", rf_wr_en, !Byp);
    chk("s1_n1_prn", rf_wr_prn, Byp ? 64'd0 : 64'd12);
    chk("s1_n1_data", rf_wr_data, Byp ? 64'd0 : 64'hDEAD);
    chk("s1_n1_done", done_valid, !Byp);
    chk("s1_n1_id", done_inst_id, Byp ? 64'd0 : 64'd5);
    next();
    chk("s1_count", dut.r_count, 0);

    // Three writes, continuous grant.
    step();
    drive(6'd2, 6'd1, 6'd2, 6'd3, 64'h11, 64'h22, 64'h33, 3'b111);
    @(negedge clk);
    chk("s2_n_en", rf_wr_en, Byp);
    if (!Byp) next();
    for (int j = 0; j < 3; j++) begin
      chk("s2_en", rf_wr_en, 1);
      chk("s2_prn", rf_wr_prn, j + 1);
      chk("s2_data", rf_wr_data, 64'h11 * (j + 1));
      chk("s2_done", done_valid, j == 2);
      chk("s2_id", done_inst_id, (j == 2) ? 64'd2 : 64'd0);
      next();
    end

    // Same bundle with the grant withheld for four cycles.
    step();
    rf_wr_grant = 1'b0;
    drive(6'd2, 6'd1, 6'd2, 6'd3, 64'h11, 64'h22, 64'h33, 3'b111);
    @(negedge clk);
    chk("s3_n_en", rf_wr_en, Byp);
    if (!Byp) next();
    for (int s = 0; s < 4; s++) begin
      chk("s3_stall_en", rf_wr_en, 1);
      chk("s3_stall_prn", rf_wr_prn, 1);
      chk("s3_stall_done", done_valid, 0);
      step();
      idle();
      if (s == 3) rf_wr_grant = 1'b1;
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      chk("s3_prn", rf_wr_prn, j + 1);
      chk("s3_done", done_valid, j == 2);
      next();
    end

    // Fill the queue with the grant low, try a fifth bundle, then drain in order.
    rf_wr_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      drive(6'(10 + i), 6'(20 + i), 6'd0, 6'd0, 64'h100 + 64'(i), 64'd0, 64'd0, 3'b001);
      @(negedge clk);
      chk("s4_fill_ready", in_ready, 1);
    end
    step();
    drive(6'd14, 6'd30, 6'd0, 6'd0, 64'h200, 64'd0, 64'd0, 3'b001);
    @(negedge clk);
    chk("s4_full_ready", in_ready, 0);
    step();
    @(negedge clk);
    chk("s4_full_ready2", in_ready, 0);
    chk("s4_full_count", dut.r_count, 4);
    step();
    idle();
    rf_wr_grant = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("s4_drain_done", done_valid, 1);
      chk("s4_drain_id", done_inst_id, 10 + i);
      chk("s4_drain_prn", rf_wr_prn, 20 + i);
      next();
    end
    chk("s4_empty_done", done_valid, 0);
    chk("s4_empty_ready", in_ready, 1);

    // No-write bundle completes without a grant.
    step();
    rf_wr_grant = 1'b0;
    drive(6'd9, 6'd4, 6'd5, 6'd6, 64'd1, 64'd2, 64'd3, 3'b000);
    @(negedge clk);
    chk("s5_n_done", done_valid, Byp);
    chk("s5_n_en", rf_wr_en, 0);
    next();
    chk("s5_n1_done", done_valid, !Byp);
    chk("s5_n1_id", done_inst_id, Byp ? 64'd0 : 64'd9);
    chk("s5_n1_en", rf_wr_en, 0);

    // Reset after the first of three writes is granted.
    step();
    rf_wr_grant = 1'b1;
    drive(6'd7, 6'd1, 6'd2, 6'd3, 64'h71, 64'h72, 64'h73, 3'b111);
    @(negedge clk);
    if (!Byp) next();
    chk("s6_w0_prn", rf_wr_prn, 1);
    chk("s6_w0_done", done_valid, 0);
    step();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("s6_rst_en", rf_wr_en, 0);
    chk("s6_rst_done", done_valid, 0);
    chk("s6_rst_ready", in_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("s6_count", dut.r_count, 0);
    chk("s6_en", rf_wr_en, 0);
    chk("s6_done", done_valid, 0);
    chk("s6_ready", in_ready, 1);

    // Mixed traffic: varied masks and an irregular grant pattern.
    for (int c = 0; c < 24; c++) begin
      step();
      rf_wr_grant = ((c * 7) % 5) != 0;
      if ((c % 3) != 2)
        drive(6'(32 + c), 6'(c), 6'(c + 1), 6'(c + 2), 64'(c * 100), 64'(c * 100 + 1),
              64'(c * 100 + 2), 3'((c * 5) % 8));
      else
        idle();
      @(negedge clk);
    end
    step();
    idle();
    rf_wr_grant = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    chk("s7_drained", dut.r_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
